// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) definitions: codeword geometry, parity equations and the
// serial encoder state encoding. Also imported by the decoder syndrome logic.
package hamming74_pkg;

    localparam int CW_BITS   = 7;
    localparam int DATA_BITS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    // Even parity bits returned as {p4, p2, p1}.
    function automatic logic [2:0] hamming74_parity(input logic [DATA_BITS-1:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {p4, p2, p1};
    endfunction

endpackage

// File: rtl/hamming74_serial_encoder_if.sv
// Nibble handshake plus serial link signals of the Hamming(7,4) transmitter.
// The master is the nibble source / link observer, the slave is the encoder.
interface hamming74_serial_encoder_if
    import hamming74_pkg::*;
();
    logic [DATA_BITS-1:0] data_in;
    logic                 data_valid;
    logic                 data_ready;
    logic                 tx_out;
    logic                 tx_frame;
    logic                 tx_done;

    modport master (
        output data_in, data_valid,
        input  data_ready, tx_out, tx_frame, tx_done
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, tx_out, tx_frame, tx_done
    );
endinterface

// File: rtl/hamming74_encode_core.sv
// Combinational Hamming(7,4) encoder: cw index = Hamming position - 1,
// so cw = {d3, d2, d1, p4, d0, p2, p1}.
module hamming74_encode_core
    import hamming74_pkg::*;
(
    input  logic [DATA_BITS-1:0] data,
    output logic [CW_BITS-1:0]   cw
);
    logic [2:0] parity;

    assign parity = hamming74_parity(data);
    assign cw     = {data[3], data[2], data[1], parity[2], data[0], parity[1], parity[0]};

endmodule

// File: rtl/hamming74_serial_encoder.sv
// Serial Hamming(7,4) transmitter: accepts a nibble, then shifts the 7-bit
// codeword out LSB-first, holding each bit for CLKS_PER_BIT clocks.
module hamming74_serial_encoder
    import hamming74_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    hamming74_serial_encoder_if.slave      bus
);
    localparam logic [7:0] TIMER_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDX_LAST   = 3'(CW_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CW_BITS-1:0]   cw_q, cw_d, cw_enc;
    logic [2:0]           bit_idx_q, bit_idx_d, bit_idx_nxt;
    logic [7:0]           bit_timer_q, bit_timer_d;
    logic                 tx_out_q, tx_out_d;
    logic                 tx_frame_q, tx_frame_d;
    logic                 bit_last, frame_last, accept;

    hamming74_encode_core u_encode_core (
        .data (bus.data_in),
        .cw   (cw_enc)
    );

    // The final frame cycle doubles as an accept slot so frames can abut.
    assign bit_last    = (state_q == SHIFT) && (bit_timer_q == TIMER_LAST);
    assign frame_last  = bit_last && (bit_idx_q == IDX_LAST);
    assign accept      = ena && bus.data_valid && ((state_q == IDLE) || frame_last);
    assign bit_idx_nxt = bit_idx_q + 3'd1;

    assign bus.data_ready = ena && ((state_q == IDLE) || frame_last);
    assign bus.tx_done    = ena && frame_last;
    assign bus.tx_out     = tx_out_q;
    assign bus.tx_frame   = tx_frame_q;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path infers a latch.
        state_d     = state_q;
        cw_d        = cw_q;
        bit_idx_d   = bit_idx_q;
        bit_timer_d = bit_timer_q;
        tx_out_d    = tx_out_q;
        tx_frame_d  = tx_frame_q;

        if (ena) begin
            if (accept) begin
                state_d     = SHIFT;
                cw_d        = cw_enc;
                bit_idx_d   = '0;
                bit_timer_d = '0;
                tx_out_d    = cw_enc[0];
                tx_frame_d  = 1'b1;
            end else if (frame_last) begin
                state_d     = IDLE;
                bit_idx_d   = '0;
                bit_timer_d = '0;
                tx_out_d    = 1'b0;
                tx_frame_d  = 1'b0;
            end else if (bit_last) begin
                bit_timer_d = '0;
                bit_idx_d   = bit_idx_nxt;
                tx_out_d    = cw_q[bit_idx_nxt];
            end else if (state_q == SHIFT) begin
                bit_timer_d = bit_timer_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cw_q        <= '0;
            bit_idx_q   <= '0;
            bit_timer_q <= '0;
            tx_out_q    <= 1'b0;
            tx_frame_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cw_q        <= cw_d;
            bit_idx_q   <= bit_idx_d;
            bit_timer_q <= bit_timer_d;
            tx_out_q    <= tx_out_d;
            tx_frame_q  <= tx_frame_d;
        end
    end

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Directed bench for the serial Hamming(7,4) encoder: one DUT at 1 clk/bit,
// one at 3 clk/bit, plus a syndrome decoder for loopback.
module tb_hamming74_serial_encoder;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hamming74_serial_encoder_if bus1 ();
    hamming74_serial_encoder_if bus3 ();

    hamming74_serial_encoder #(.CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus1)
    );

    hamming74_serial_encoder #(.CLKS_PER_BIT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus3)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Independent syndrome decoder: corrects one flipped bit, returns {d3,d2,d1,d0}.
    function automatic logic [3:0] decode(input logic [6:0] c_in);
        logic [6:0] c;
        logic [2:0] syn;
        c      = c_in;
        syn[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        syn[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        syn[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        if (syn != 3'd0) c[syn - 3'd1] = ~c[syn - 3'd1];
        return {c[6], c[5], c[4], c[2]};
    endfunction

    // Present a nibble to dut1 for one cycle; returns at the first frame cycle.
    task automatic send1(input logic [3:0] d);
        @(negedge clk);
        n_checks++;
        if (bus1.data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send1 data_ready: got %b want 1", bus1.data_ready);
        end
        bus1.data_valid = 1'b1;
        bus1.data_in    = d;
        @(negedge clk);
        bus1.data_valid = 1'b0;
        bus1.data_in    = ~d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        bus1.data_valid = 1'b0; bus1.data_in = 4'h0;
        bus3.data_valid = 1'b0; bus3.data_in = 4'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus1.tx_out, bus1.tx_frame, bus1.tx_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset outputs: got %b want 000", {bus1.tx_out, bus1.tx_frame, bus1.tx_done});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus1.data_ready !== 1'b1 || bus3.data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset data_ready: got %b%b want 11", bus1.data_ready, bus3.data_ready);
        end
        n_checks++;
        if ({bus3.tx_out, bus3.tx_frame, bus3.tx_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset outputs3: got %b want 000", {bus3.tx_out, bus3.tx_frame, bus3.tx_done});
        end
    endtask

    task automatic test_single_frame();
        logic [6:0] exp_cw;
        exp_cw = 7'h55;
        send1(4'b1011);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({bus1.tx_out, bus1.tx_frame, bus1.tx_done, bus1.data_ready} !==
                {exp_cw[3'(i)], 1'b1, (i == 6), (i == 6)}) begin
                n_fail++;
                $display("FAIL single cycle %0d out/frame/done/ready: got %b want %b", i,
                         {bus1.tx_out, bus1.tx_frame, bus1.tx_done, bus1.data_ready},
                         {exp_cw[3'(i)], 1'b1, (i == 6), (i == 6)});
            end
        end
        @(negedge clk);
        n_checks++;
        if ({bus1.tx_out, bus1.tx_frame, bus1.tx_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL single after-frame: got %b want 000", {bus1.tx_out, bus1.tx_frame, bus1.tx_done});
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp_bits;
        exp_bits = {7'h7F, 7'b0000111};
        @(negedge clk);
        bus1.data_valid = 1'b1;
        bus1.data_in    = 4'b0001;
        @(negedge clk);
        bus1.data_in    = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 7) bus1.data_valid = 1'b0;
            n_checks++;
            if ({bus1.tx_out, bus1.tx_frame, bus1.tx_done} !==
                {exp_bits[4'(i)], 1'b1, (i == 6 || i == 13)}) begin
                n_fail++;
                $display("FAIL b2b cycle %0d out/frame/done: got %b want %b", i,
                         {bus1.tx_out, bus1.tx_frame, bus1.tx_done},
                         {exp_bits[4'(i)], 1'b1, (i == 6 || i == 13)});
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus1.tx_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b frame end: got %b want 0", bus1.tx_frame);
        end
    endtask

    task automatic test_slow_bits();
        @(negedge clk);
        bus3.data_valid = 1'b1;
        bus3.data_in    = 4'b0000;
        @(negedge clk);
        bus3.data_valid = 1'b0;
        bus3.data_in    = 4'b1111;
        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({bus3.tx_out, bus3.tx_frame, bus3.tx_done, bus3.data_ready} !==
                {1'b0, 1'b1, (i == 20), (i == 20)}) begin
                n_fail++;
                $display("FAIL slow cycle %0d out/frame/done/ready: got %b want %b", i,
                         {bus3.tx_out, bus3.tx_frame, bus3.tx_done, bus3.data_ready},
                         {1'b0, 1'b1, (i == 20), (i == 20)});
            end
        end
        @(negedge clk);
        n_checks++;
        if ({bus3.tx_frame, bus3.data_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL slow after-frame frame/ready: got %b want 01", {bus3.tx_frame, bus3.data_ready});
        end
    endtask

    task automatic test_enable_stall();
        logic [11:0] exp_bits;
        exp_bits = 12'b1010_1111_1101;
        send1(4'b1011);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            ena = !(i >= 2 && i <= 6);
            n_checks++;
            if ({bus1.tx_out, bus1.tx_frame, bus1.tx_done} !== {exp_bits[4'(i)], 1'b1, (i == 11)}) begin
                n_fail++;
                $display("FAIL stall cycle %0d out/frame/done: got %b want %b", i,
                         {bus1.tx_out, bus1.tx_frame, bus1.tx_done}, {exp_bits[4'(i)], 1'b1, (i == 11)});
            end
            if (!ena) begin
                n_checks++;
                if (bus1.data_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall cycle %0d data_ready: got %b want 0", i, bus1.data_ready);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus1.tx_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL stall frame end: got %b want 0", bus1.tx_frame);
        end
    endtask

    task automatic test_reset_midframe();
        logic [6:0] exp_cw;
        exp_cw = 7'b0000111;
        send1(4'b1011);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({bus1.tx_out, bus1.tx_frame} !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset bit4 out/frame: got %b want 11", {bus1.tx_out, bus1.tx_frame});
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus1.tx_out, bus1.tx_frame, bus1.tx_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset outputs: got %b want 000", {bus1.tx_out, bus1.tx_frame, bus1.tx_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send1(4'b0001);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({bus1.tx_out, bus1.tx_frame, bus1.tx_done} !== {exp_cw[3'(i)], 1'b1, (i == 6)}) begin
                n_fail++;
                $display("FAIL postreset cycle %0d out/frame/done: got %b want %b", i,
                         {bus1.tx_out, bus1.tx_frame, bus1.tx_done}, {exp_cw[3'(i)], 1'b1, (i == 6)});
            end
        end
    endtask

    task automatic test_loopback();
        logic [6:0] rx;
        logic [6:0] bad;
        logic [3:0] nib;
        for (int n = 0; n < 16; n++) begin
            nib = 4'(n);
            send1(nib);
            for (int i = 0; i < 7; i++) begin
                if (i > 0) @(negedge clk);
                rx[3'(i)] = bus1.tx_out;
            end
            for (int f = -1; f < 7; f++) begin
                bad = rx;
                if (f >= 0) bad[3'(f)] = ~bad[3'(f)];
                n_checks++;
                if (decode(bad) !== nib) begin
                    n_fail++;
                    $display("FAIL loopback nibble %h flip %0d: got %h want %h", nib, f, decode(bad), nib);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_slow_bits();
        test_enable_stall();
        test_reset_midframe();
        test_loopback();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
